wb_gpio_ctrl: RTL and testbench

Parametrised Wishbone-slave GPIO controller with per-pin direction control, atomic set/clear/toggle of outputs, a synchronised input path, and per-pin edge-detect interrupts. It hangs off the system Wishbone bus as a single register window. It drives GPIO_WIDTH pads plus one level interrupt line to the interrupt controller.

---
 rtl/wb_gpio_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wb_gpio_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_gpio_ctrl
//  Description : Wishbone-slave GPIO controller. Per-pin direction, atomic
//                set/clear/toggle of the output register, synchronised input
//                path and per-pin rising/falling edge interrupts with a
//                write-1-to-clear status register and one level IRQ line.
//  Ports       : clk_i/rst_i       clock, asynchronous active-low reset
//                wb_*              Wishbone slave (registered ack and read data)
//                gpio_i            asynchronous pad inputs
//                gpio_o/gpio_oe_o  pad output values / output enables
//                irq_o             level interrupt, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_gpio_ctrl #(
    parameter int          GPIO_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_we_i,
    output logic                  wb_ack_o,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [3:0]            wb_sel_i,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  irq_o
);

    localparam logic [GPIO_WIDTH-1:0] OUT_RESET_M = OUT_RESET[GPIO_WIDTH-1:0];

    localparam logic [3:0] REG_DATA_IN  = 4'd0;
    localparam logic [3:0] REG_DATA_OUT = 4'd1;
    localparam logic [3:0] REG_DIR      = 4'd2;
    localparam logic [3:0] REG_IRQ_EN   = 4'd3;
    localparam logic [3:0] REG_IRQ_RISE = 4'd4;
    localparam logic [3:0] REG_IRQ_FALL = 4'd5;
    localparam logic [3:0] REG_IRQ_STAT = 4'd6;
    localparam logic [3:0] REG_OUT_SET  = 4'd7;
    localparam logic [3:0] REG_OUT_CLR  = 4'd8;
    localparam logic [3:0] REG_OUT_TGL  = 4'd9;

    // Register state
    logic [GPIO_WIDTH-1:0] data_out;
    logic [GPIO_WIDTH-1:0] dir;
    logic [GPIO_WIDTH-1:0] irq_en;
    logic [GPIO_WIDTH-1:0] irq_rise;
    logic [GPIO_WIDTH-1:0] irq_fall;
    logic [GPIO_WIDTH-1:0] irq_stat;
    logic [GPIO_WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] prev;
    logic                  ack;

    // Combinational helpers
    logic [GPIO_WIDTH-1:0] sync;
    logic [GPIO_WIDTH-1:0] rise_evt;
    logic [GPIO_WIDTH-1:0] fall_evt;
    logic [GPIO_WIDTH-1:0] wmask;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] stat_clr;
    logic [GPIO_WIDTH-1:0] rd_word;
    logic [31:0]           rd_data;
    logic [31:0]           byte_mask;
    logic [3:0]            idx;
    logic                  access;
    logic                  wr;
    logic                  unused_bits;

    assign idx    = wb_adr_i[5:2];
    // A new access is only taken while the ack flop is low, so a held strobe
    // yields one transfer every second cycle.
    assign access = wb_stb_i & wb_cyc_i & ~ack;
    assign wr     = access & wb_we_i;

    assign wb_ack_o  = ack & wb_stb_i & wb_cyc_i;
    assign gpio_o    = data_out;
    assign gpio_oe_o = dir;

    assign sync     = sync_ff[SYNC_STAGES-1];
    assign rise_evt = sync & ~prev & irq_rise;
    assign fall_evt = ~sync & prev & irq_fall;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{wb_sel_i[i]}};
        end
    end

    // Deselected byte lanes behave as zero data, which makes the same masked
    // value usable for plain writes, W1C and the set/clear/toggle ports.
    assign wmask    = byte_mask[GPIO_WIDTH-1:0];
    assign wdata    = wb_dat_i[GPIO_WIDTH-1:0] & wmask;
    assign stat_clr = (wr && (idx == REG_IRQ_STAT)) ? wdata : '0;

    always_comb begin
        rd_word = '0;
        case (idx)
            REG_DATA_IN:  rd_word = sync;
            REG_DATA_OUT: rd_word = data_out;
            REG_DIR:      rd_word = dir;
            REG_IRQ_EN:   rd_word = irq_en;
            REG_IRQ_RISE: rd_word = irq_rise;
            REG_IRQ_FALL: rd_word = irq_fall;
            REG_IRQ_STAT: rd_word = irq_stat;
            default:      rd_word = '0;
        endcase
    end

    always_comb begin
        rd_data                   = '0;
        rd_data[GPIO_WIDTH-1:0]   = rd_word;
    end

    assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, byte_mask};

    // Input synchroniser
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_ff[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
            prev <= sync;
        end
    end

    // Bus handshake, interrupt status and register file
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
            data_out <= OUT_RESET_M;
            dir      <= '0;
            irq_en   <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
            irq_stat <= '0;
        end else begin
            ack   <= access;
            irq_o <= |(irq_stat & irq_en);
            // Edge events are OR-ed in after the clear so a coincident edge wins.
            irq_stat <= (irq_stat & ~stat_clr) | rise_evt | fall_evt;
            if (access) begin
                wb_dat_o <= rd_data;
            end
            if (wr) begin
                case (idx)
                    REG_DATA_OUT: data_out <= (data_out & ~wmask) | wdata;
                    REG_DIR:      dir      <= (dir      & ~wmask) | wdata;
                    REG_IRQ_EN:   irq_en   <= (irq_en   & ~wmask) | wdata;
                    REG_IRQ_RISE: irq_rise <= (irq_rise & ~wmask) | wdata;
                    REG_IRQ_FALL: irq_fall <= (irq_fall & ~wmask) | wdata;
                    REG_OUT_SET:  data_out <= data_out | wdata;
                    REG_OUT_CLR:  data_out <= data_out & ~wdata;
                    REG_OUT_TGL:  data_out <= data_out ^ wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_gpio_ctrl
//  Description : Self-checking bench for wb_gpio_ctrl. A behavioural model
//                queues expected bus responses; a monitor compares them and
//                the pad/irq outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_ctrl;

    localparam int W  = 32;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0]   adr = '0, dat = '0;
    logic [3:0]    sel = '0;
    logic [W-1:0]  gpio_i = '0;
    logic          wb_ack_o, irq_o;
    logic [31:0]   wb_dat_o;
    logic [W-1:0]  gpio_o, gpio_oe_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_gpio_ctrl #(.GPIO_WIDTH(W), .SYNC_STAGES(SS), .OUT_RESET(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_n), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_we_i(we), .wb_ack_o(wb_ack_o), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(wb_dat_o), .wb_sel_i(sel), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    logic [31:0] m_out, m_dir, m_en, m_rise, m_fall, m_stat;
    logic        m_irq, m_ack;
    logic [31:0] samp [1:SS+1];   // samp[j] = gpio_i seen j clock edges ago

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] bm, d, syn, prv, ev, rdv;
        logic        acc;
        exp_t        e;
        if (!rst_n) begin
            m_out <= '0; m_dir <= '0; m_en <= '0; m_rise <= '0; m_fall <= '0;
            m_stat <= '0; m_irq <= 1'b0; m_ack <= 1'b0;
            for (int j = 1; j <= SS + 1; j++) samp[j] <= '0;
            expq.delete();
        end else begin
            syn = samp[SS];
            prv = samp[SS+1];
            ev  = (syn & ~prv & m_rise) | (~syn & prv & m_fall);
            bm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            d   = dat & bm;
            acc = stb && cyc && !m_ack;
            m_ack <= acc;
            m_irq <= |(m_stat & m_en);
            if (acc && we && adr[5:2] == 4'd6) m_stat <= (m_stat & ~d) | ev;
            else                               m_stat <= m_stat | ev;
            if (acc) begin
                case (adr[5:2])
                    4'd0: rdv = syn;
                    4'd1: rdv = m_out;
                    4'd2: rdv = m_dir;
                    4'd3: rdv = m_en;
                    4'd4: rdv = m_rise;
                    4'd5: rdv = m_fall;
                    4'd6: rdv = m_stat;
                    default: rdv = '0;
                endcase
                e.is_rd = !we;
                e.data  = rdv;
                expq.push_back(e);
                if (we) begin
                    case (adr[5:2])
                        4'd1: m_out  <= (m_out  & ~bm) | d;
                        4'd2: m_dir  <= (m_dir  & ~bm) | d;
                        4'd3: m_en   <= (m_en   & ~bm) | d;
                        4'd4: m_rise <= (m_rise & ~bm) | d;
                        4'd5: m_fall <= (m_fall & ~bm) | d;
                        4'd7: m_out  <= m_out | d;
                        4'd8: m_out  <= m_out & ~d;
                        4'd9: m_out  <= m_out ^ d;
                        default: ;
                    endcase
                end
            end
            for (int j = SS + 1; j >= 2; j--) samp[j] <= samp[j-1];
            samp[1] <= gpio_i;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic ea;
        exp_t e;
        ea = m_ack && stb && cyc;
        chk("ack", {31'b0, wb_ack_o}, {31'b0, ea});
        if (ea) begin
            if (expq.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = expq.pop_front();
                if (e.is_rd) chk("rdata", wb_dat_o, e.data);
            end
        end
        chk("gpio_o", gpio_o, m_out);
        chk("gpio_oe_o", gpio_oe_o, m_dir);
        chk("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
    end

    // ---------------- bus tasks ----------------
    task automatic bus(input logic w, input logic [3:0] idx, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        bit got = 0;
        rd = '0;
        @(posedge clk); #2;
        stb = 1'b1; cyc = 1'b1; we = w; adr = {26'b0, idx, 2'b00}; dat = d; sel = s;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                rd  = wb_dat_o;
                got = 1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(1'b1, idx, d, s, dummy);
    endtask

    task automatic rd(input logic [3:0] idx, output logic [31:0] v);
        bus(1'b0, idx, 32'h0, 4'hF, v);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] v;
        int          n;
        #22 rst_n = 1'b1;

        // reset read-back
        for (int i = 0; i < 10; i++) begin
            rd(i[3:0], v);
            chk("reset_rd", v, 32'h0);
        end
        chk("reset_oe", gpio_oe_o, 32'h0);
        chk("reset_irq", {31'b0, irq_o}, 32'h0);

        // byte lanes
        wr(4'd1, 32'hAABB_CCDD, 4'b0101);
        rd(4'd1, v);
        chk("bytelane_rd", v, 32'h00BB_00DD);
        chk("bytelane_pad", gpio_o, 32'h00BB_00DD);
        wr(4'd2, 32'hFFFF_FFFF, 4'hF);
        chk("dir_all", gpio_oe_o, 32'hFFFF_FFFF);

        // atomic ops
        wr(4'd1, 32'h0000_00F0, 4'hF);
        wr(4'd7, 32'h0000_000F, 4'hF);
        rd(4'd1, v); chk("set", v, 32'h0000_00FF);
        wr(4'd8, 32'h0000_0030, 4'hF);
        rd(4'd1, v); chk("clr", v, 32'h0000_00CF);
        wr(4'd9, 32'h0000_0101, 4'hF);
        rd(4'd1, v); chk("tgl", v, 32'h0000_01CE);
        rd(4'd7, v); chk("set_reads0", v, 32'h0);

        // rising-edge interrupt on pin 3
        wr(4'd4, 32'h8, 4'hF);
        wr(4'd3, 32'h8, 4'hF);
        @(posedge clk); #2 gpio_i[3] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("irq_lag", {31'b0, irq_o}, 32'h0);
        @(posedge clk);
        @(negedge clk); chk("irq_rise", {31'b0, irq_o}, 32'h1);
        rd(4'd6, v); chk("stat_rise", v, 32'h8);
        wr(4'd6, 32'h8, 4'hF);
        chk("irq_cleared", {31'b0, irq_o}, 32'h0);
        rd(4'd6, v); chk("stat_cleared", v, 32'h0);

        // falling edge with enable masked
        wr(4'd5, 32'h1, 4'hF);
        wr(4'd3, 32'h0, 4'hF);
        @(posedge clk); #2 gpio_i[0] = 1'b1;
        repeat (5) @(posedge clk);
        #2 gpio_i[0] = 1'b0;
        repeat (5) @(posedge clk);
        rd(4'd6, v); chk("stat_fall", v, 32'h1);
        chk("irq_masked", {31'b0, irq_o}, 32'h0);

        // W1C colliding with a new rising edge on pin 3
        @(posedge clk); #2 gpio_i[3] = 1'b0;
        repeat (5) @(posedge clk);
        #2 gpio_i[3] = 1'b1;
        @(posedge clk);
        wr(4'd6, 32'h8, 4'hF);
        rd(4'd6, v); chk("collision", v, 32'h9);

        // strobe held six cycles
        @(posedge clk); #2;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack_o) n++;
        end
        @(posedge clk); #2 stb = 1'b0; cyc = 1'b0;
        chk("held_acks", n, 32'd3);

        // reset in the middle of a transfer
        gpio_i = '0;
        repeat (5) @(posedge clk);
        #2 stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h4; dat = 32'h5555_5555;
        #3 rst_n = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_ack_o) n++;
        end
        chk("rst_no_ack", n, 32'd0);
        @(posedge clk); #2 stb = 1'b0; cyc = 1'b0; we = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd(i[3:0], v);
            chk("rst_rd", v, 32'h0);
        end
        chk("rst_oe", gpio_oe_o, 32'h0);

        // randomized traffic checked by the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(2) == 0) gpio_i = $urandom;
            if ($urandom_range(7) == 0) begin
                @(posedge clk); #2 cyc = 1'b1; stb = 1'b0;
                @(posedge clk); #2 cyc = 1'b0;
            end
            bus($urandom_range(1) == 1, 4'($urandom_range(15)), $urandom,
                4'($urandom_range(15)), v);
        end
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
